// File: rtl/video_pkg.sv
// Shared types, register map and reset constants for the video layer register file.
package video_pkg;

   localparam int unsigned ADDR_W       = 5;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned CFG_W        = 24;
   localparam int unsigned LAYER_BYTES  = 3;
   localparam int unsigned LAYER_STRIDE = 3;
   localparam int unsigned LAYER0_BASE  = 4;
   localparam int unsigned MAX_LAYERS   = 8;

   localparam logic [ADDR_W-1:0] REG_PAL_BASE  = 5'h00;
   localparam logic [ADDR_W-1:0] REG_CTRL      = 5'h01;
   localparam logic [ADDR_W-1:0] REG_STATUS    = 5'h02;
   localparam logic [ADDR_W-1:0] REG_FRAME_CNT = 5'h03;

   localparam int unsigned CTRL_SHADOW_EN = 0;
   localparam int unsigned CTRL_COMMIT    = 1;
   localparam int unsigned CTRL_IRQ_MASK  = 2;
   localparam int unsigned STATUS_PENDING = 0;
   localparam int unsigned STATUS_IRQ     = 2;

   localparam logic [DATA_W-1:0] PAL_BASE_RESET = 8'hFF;

   typedef struct packed {
      logic [1:0] map_w;
      logic [1:0] map_h;
      logic       bitmap;
      logic       enable;
      logic [1:0] depth;
      logic [5:0] map_base;
      logic       pix_dbl;
      logic       line_dbl;
      logic [5:0] tile_base;
      logic       tile_w;
      logic       tile_h;
   } layer_cfg_t;

   localparam layer_cfg_t LAYER_CFG_RESET = layer_cfg_t'(24'h08_0000);

   // First register address owned by layer slot n.
   function automatic logic [ADDR_W-1:0] slot_base(input int unsigned n);
      return ADDR_W'(LAYER0_BASE + LAYER_STRIDE * n);
   endfunction

endpackage

// File: rtl/video_layer_regs_if.sv
// Wishbone slave bus bundle for the video layer register file.
interface video_layer_regs_if;
   import video_pkg::*;

   logic [ADDR_W-1:0] wb_addr_i;
   logic [DATA_W-1:0] wb_data_i;
   logic [DATA_W-1:0] wb_data_o;
   logic              wb_strobe_i;
   logic              wb_write_i;
   logic              wb_ack_o;
   logic              wb_stall_o;

   modport slave (
      input  wb_addr_i, wb_data_i, wb_strobe_i, wb_write_i,
      output wb_data_o, wb_ack_o, wb_stall_o
   );

   modport master (
      output wb_addr_i, wb_data_i, wb_strobe_i, wb_write_i,
      input  wb_data_o, wb_ack_o, wb_stall_o
   );

endinterface

// File: rtl/video_layer_slot.sv
// One layer slot: 3-byte staging copy, active copy, address decode and read mux.
module video_layer_slot
   import video_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              we,
   input  logic              shadow_en,
   input  logic              load,
   output layer_cfg_t        active,
   output logic [DATA_W-1:0] rdata_c
);

   layer_cfg_t        staging;
   logic [ADDR_W-1:0] offset_c;
   logic              hit_c;

   assign offset_c = addr - base;
   assign hit_c    = (addr >= base) && (offset_c < ADDR_W'(LAYER_BYTES));

   // CFG0 lives in the top byte of the struct, CFG2 in the bottom byte.
   always_comb begin
      rdata_c = '0;
      if (hit_c) begin
         case (offset_c[1:0])
            2'd0:    rdata_c = staging[23:16];
            2'd1:    rdata_c = staging[15:8];
            2'd2:    rdata_c = staging[7:0];
            default: rdata_c = '0;
         endcase
      end
   end

   // A load copies the pre-write staging; an unshadowed write also lands in active.
   always_ff @(posedge clk) begin
      if (rst) begin
         staging <= LAYER_CFG_RESET;
         active  <= LAYER_CFG_RESET;
      end else begin
         if (load) active <= staging;
         if (we && hit_c) begin
            case (offset_c[1:0])
               2'd0: begin
                  staging[23:16] <= wdata;
                  if (!shadow_en) active[23:16] <= wdata;
               end
               2'd1: begin
                  staging[15:8] <= wdata;
                  if (!shadow_en) active[15:8] <= wdata;
               end
               2'd2: begin
                  staging[7:0] <= wdata;
                  if (!shadow_en) active[7:0] <= wdata;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/video_layer_regs.sv
// Wishbone register file holding palette base and per-layer config with optional frame-synchronous commit.
// Optional frame interrupt is built when VIDEO_FRAME_IRQ_EN is defined.
module video_layer_regs
   import video_pkg::*;
#(
   parameter int unsigned NUM_LAYERS = 4
)(
   input  logic                          wb_clk_i,
   input  logic                          wb_reset_i,
   video_layer_regs_if.slave             wb,
   input  logic                          next_frame_i,
   output logic [DATA_W-1:0]             pal_base_o,
   output layer_cfg_t [NUM_LAYERS-1:0]   layer_cfg_o,
   output logic                          commit_pending_o
`ifdef VIDEO_FRAME_IRQ_EN
   ,
   output logic                          irq_o
`endif
);

   logic              wr_c;
   logic              rd_c;
   logic              ctrl_wr_c;
   logic              pal_wr_c;
   logic              commit_set_c;
   logic              shadow_fall_c;
   logic              load_c;
   logic              pending_d;
   logic [DATA_W-1:0] rdata_c;
   logic [DATA_W-1:0] slot_rdata [NUM_LAYERS];

   logic              shadow_en_q;
   logic [DATA_W-1:0] pal_stg_q;
   logic [DATA_W-1:0] frame_cnt_q;
   logic              irq_flag_q;
   logic              irq_mask_q;

   assign wb.wb_stall_o = 1'b0;

   assign wr_c      = wb.wb_strobe_i &  wb.wb_write_i;
   assign rd_c      = wb.wb_strobe_i & ~wb.wb_write_i;
   assign ctrl_wr_c = wr_c && (wb.wb_addr_i == REG_CTRL);
   assign pal_wr_c  = wr_c && (wb.wb_addr_i == REG_PAL_BASE);

   // Commit only arms when the same write leaves shadowing enabled.
   assign commit_set_c  = ctrl_wr_c & wb.wb_data_i[CTRL_COMMIT] & wb.wb_data_i[CTRL_SHADOW_EN];
   assign shadow_fall_c = ctrl_wr_c & ~wb.wb_data_i[CTRL_SHADOW_EN] & shadow_en_q;
   assign load_c        = commit_pending_o & (next_frame_i | shadow_fall_c);

   always_comb begin
      pending_d = commit_pending_o;
      if (next_frame_i || shadow_fall_c) pending_d = 1'b0;
      if (commit_set_c)                  pending_d = 1'b1;
   end

`ifdef VIDEO_FRAME_IRQ_EN
   logic status_wr_c;
   logic irq_flag_d;
   logic irq_mask_d;

   assign status_wr_c = wr_c && (wb.wb_addr_i == REG_STATUS);
   // A frame pulse wins over a simultaneous clear.
   assign irq_flag_d  = next_frame_i |
                        (irq_flag_q & ~(status_wr_c & wb.wb_data_i[STATUS_IRQ]));
   assign irq_mask_d  = ctrl_wr_c ? wb.wb_data_i[CTRL_IRQ_MASK] : irq_mask_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_reset_i) begin
         irq_flag_q <= 1'b0;
         irq_mask_q <= 1'b0;
         irq_o      <= 1'b0;
      end else begin
         irq_flag_q <= irq_flag_d;
         irq_mask_q <= irq_mask_d;
         irq_o      <= irq_flag_d & irq_mask_d;
      end
   end
`else
   assign irq_flag_q = 1'b0;
   assign irq_mask_q = 1'b0;
`endif

   // Read mux returns staging values; unmapped addresses fall through to zero.
   always_comb begin
      rdata_c = '0;
      case (wb.wb_addr_i)
         REG_PAL_BASE:  rdata_c = pal_stg_q;
         REG_CTRL: begin
            rdata_c[CTRL_SHADOW_EN] = shadow_en_q;
            rdata_c[CTRL_IRQ_MASK]  = irq_mask_q;
         end
         REG_STATUS: begin
            rdata_c[STATUS_PENDING] = commit_pending_o;
            rdata_c[STATUS_IRQ]     = irq_flag_q;
         end
         REG_FRAME_CNT: rdata_c = frame_cnt_q;
         default: begin
            for (int i = 0; i < int'(NUM_LAYERS); i++) rdata_c = rdata_c | slot_rdata[i];
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_reset_i) begin
         wb.wb_ack_o      <= 1'b0;
         wb.wb_data_o     <= '0;
         shadow_en_q      <= 1'b0;
         commit_pending_o <= 1'b0;
         frame_cnt_q      <= '0;
         pal_stg_q        <= PAL_BASE_RESET;
         pal_base_o       <= PAL_BASE_RESET;
      end else begin
         wb.wb_ack_o      <= wb.wb_strobe_i;
         commit_pending_o <= pending_d;
         if (rd_c)         wb.wb_data_o <= rdata_c;
         if (next_frame_i) frame_cnt_q  <= frame_cnt_q + DATA_W'(1);
         if (ctrl_wr_c)    shadow_en_q  <= wb.wb_data_i[CTRL_SHADOW_EN];
         if (load_c)       pal_base_o   <= pal_stg_q;
         if (pal_wr_c) begin
            pal_stg_q <= wb.wb_data_i;
            if (!shadow_en_q) pal_base_o <= wb.wb_data_i;
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_LAYERS); g++) begin : g_slot
      video_layer_slot u_slot (
         .clk       (wb_clk_i),
         .rst       (wb_reset_i),
         .base      (slot_base(g)),
         .addr      (wb.wb_addr_i),
         .wdata     (wb.wb_data_i),
         .we        (wr_c),
         .shadow_en (shadow_en_q),
         .load      (load_c),
         .active    (layer_cfg_o[g]),
         .rdata_c   (slot_rdata[g])
      );
   end

endmodule

// File: tb/tb_video_layer_regs.sv
// Randomized bench for video_layer_regs against an address-indexed register image model.
module tb_video_layer_regs;
   import video_pkg::*;

   localparam int unsigned NL = 2;

   logic clk = 1'b0;
   logic rst;
   logic next_frame;
   logic [DATA_W-1:0] pal_base;
   layer_cfg_t [NL-1:0] layer_cfg;
   logic pending;
`ifdef VIDEO_FRAME_IRQ_EN
   logic irq;
`endif

   video_layer_regs_if bus ();

   video_layer_regs #(.NUM_LAYERS(NL)) dut (
      .wb_clk_i         (clk),
      .wb_reset_i       (rst),
      .wb               (bus),
      .next_frame_i     (next_frame),
      .pal_base_o       (pal_base),
      .layer_cfg_o      (layer_cfg),
      .commit_pending_o (pending)
`ifdef VIDEO_FRAME_IRQ_EN
      ,
      .irq_o            (irq)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Register image: staging and active bytes indexed by bus address.
   logic [7:0] m_stg [32];
   logic [7:0] m_act [32];
   bit         m_shadow, m_pend, m_mask, m_flag, m_ack, m_irq;
   logic [7:0] m_fcnt, m_rdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_data(input int a);
      return (a == 0) || (a >= 4 && a < 4 + 3 * int'(NL));
   endfunction

   function automatic logic [7:0] m_read(input int a);
      case (a)
         0:       return m_stg[0];
         1:       return {5'b0, m_mask, 1'b0, m_shadow};
         2:       return {5'b0, m_flag, 1'b0, m_pend};
         3:       return m_fcnt;
         default: return is_data(a) ? m_stg[a] : 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_stg[i] = 8'h00;
         m_act[i] = 8'h00;
      end
      m_stg[0] = 8'hFF;
      m_act[0] = 8'hFF;
      for (int n = 0; n < int'(NL); n++) begin
         m_stg[4 + 3 * n] = 8'h08;
         m_act[4 + 3 * n] = 8'h08;
      end
      {m_shadow, m_pend, m_mask, m_flag, m_ack, m_irq} = '0;
      m_fcnt  = 8'h00;
      m_rdata = 8'h00;
   endtask

   task automatic model_step(input bit r, input bit s, input bit w,
                             input int a, input logic [7:0] d, input bit nf);
      bit copy, wr, pend_n;
      if (r) begin
         model_reset();
         return;
      end
      wr   = s && w;
      copy = m_pend && (nf || (wr && a == 1 && m_shadow && !d[0]));
      if (s && !w) m_rdata = m_read(a);
      m_ack = s;
      if (copy) for (int i = 0; i < 32; i++) m_act[i] = m_stg[i];
      pend_n = m_pend && !nf;
      if (wr && is_data(a)) begin
         m_stg[a] = d;
         if (!m_shadow) m_act[a] = d;
      end
      if (wr && a == 1) begin
         if (!d[0])     pend_n = 1'b0;
         else if (d[1]) pend_n = 1'b1;
         m_shadow = d[0];
`ifdef VIDEO_FRAME_IRQ_EN
         m_mask = d[2];
`endif
      end
      m_pend = pend_n;
      if (nf) m_fcnt = m_fcnt + 8'd1;
`ifdef VIDEO_FRAME_IRQ_EN
      if (wr && a == 2 && d[2]) m_flag = 1'b0;
      if (nf) m_flag = 1'b1;
      m_irq = m_flag && m_mask;
`endif
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pal_base", 32'(pal_base), 32'(m_act[0]));
         for (int n = 0; n < int'(NL); n++)
            chk("layer_cfg", 32'(layer_cfg[n]),
                32'({m_act[4 + 3 * n], m_act[5 + 3 * n], m_act[6 + 3 * n]}));
         chk("pending", 32'(pending), 32'(m_pend));
         chk("ack", 32'(bus.wb_ack_o), 32'(m_ack));
         chk("rdata", 32'(bus.wb_data_o), 32'(m_rdata));
         chk("stall", 32'(bus.wb_stall_o), 32'd0);
`ifdef VIDEO_FRAME_IRQ_EN
         chk("irq", 32'(irq), 32'(m_irq));
`endif
      end
   end

   task automatic cycle(input bit r, input bit s, input bit w,
                        input int a, input logic [7:0] d, input bit nf);
      rst             = r;
      bus.wb_strobe_i = s;
      bus.wb_write_i  = w;
      bus.wb_addr_i   = 5'(a);
      bus.wb_data_i   = d;
      next_frame      = nf;
      @(posedge clk);
      model_step(r, s, w, a, d, nf);
      @(negedge clk);
   endtask

   task automatic wr(input int a, input logic [7:0] d, input bit nf);
      cycle(1'b0, 1'b1, 1'b1, a, d, nf);
   endtask

   task automatic rd(input int a);
      cycle(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b0);
   endtask

   task automatic idle(input bit nf);
      cycle(1'b0, 1'b0, 1'b0, 0, 8'h00, nf);
   endtask

   initial begin
      cycle(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
      chk_en = 1'b1;
      cycle(1'b1, 1'b1, 1'b1, 4, 8'h77, 1'b1);
      chk("rst_pal", 32'(pal_base), 32'h0000_00FF);
      chk("rst_layer0", 32'(layer_cfg[0]), 32'h0008_0000);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);

      rd(0);
      chk("rd_pal", 32'(bus.wb_data_o), 32'h0000_00FF);
      rd(4);
      chk("rd_cfg0", 32'(bus.wb_data_o), 32'h0000_0008);
      rd(5);
      chk("rd_cfg1", 32'(bus.wb_data_o), 32'h0000_0000);
      chk("bitmap0", 32'(layer_cfg[0].bitmap), 32'd1);

      wr(4, 8'hA5, 1'b0);
      chk("direct_cfg0", 32'(layer_cfg[0][23:16]), 32'h0000_00A5);
      rd(4);
      chk("direct_rd", 32'(bus.wb_data_o), 32'h0000_00A5);

      wr(1, 8'h01, 1'b0);
      wr(7, 8'h3C, 1'b0);
      wr(1, 8'h03, 1'b0);
      chk("shadow_hold", 32'(layer_cfg[1][23:16]), 32'h0000_0008);
      chk("shadow_pend", 32'(pending), 32'd1);
      idle(1'b1);
      chk("commit_apply", 32'(layer_cfg[1][23:16]), 32'h0000_003C);
      chk("commit_clr", 32'(pending), 32'd0);

      wr(7, 8'h55, 1'b0);
      wr(1, 8'h03, 1'b1);
      chk("coinc_hold", 32'(layer_cfg[1][23:16]), 32'h0000_003C);
      chk("coinc_pend", 32'(pending), 32'd1);
      idle(1'b1);
      chk("coinc_apply", 32'(layer_cfg[1][23:16]), 32'h0000_0055);
      chk("coinc_clr", 32'(pending), 32'd0);

      wr(8'h0A, 8'hFF, 1'b0);
      rd(8'h0A);
      chk("unmapped_rd", 32'(bus.wb_data_o), 32'h0000_0000);

`ifdef VIDEO_FRAME_IRQ_EN
      wr(1, 8'h04, 1'b0);
      idle(1'b1);
      chk("irq_set", 32'(irq), 32'd1);
      wr(2, 8'h04, 1'b0);
      chk("irq_clr", 32'(irq), 32'd0);
      idle(1'b1);
      wr(2, 8'h04, 1'b1);
      chk("irq_set_wins", 32'(irq), 32'd1);
`endif

      cycle(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
      for (int i = 0; i < 255; i++) idle(1'b1);
      rd(3);
      chk("fcnt_ff", 32'(bus.wb_data_o), 32'h0000_00FF);
      idle(1'b1);
      rd(3);
      chk("fcnt_wrap", 32'(bus.wb_data_o), 32'h0000_0000);

      for (int i = 0; i < 4000; i++) begin
         bit r, s, w, nf;
         int a;
         r  = ($urandom_range(0, 299) == 0);
         s  = ($urandom_range(0, 3) != 0);
         w  = $urandom_range(0, 1) != 0;
         nf = ($urandom_range(0, 7) == 0);
         a  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
         cycle(r, s, w, a, 8'($urandom), nf);
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
